// File: rtl/noc_credit_link_if.sv
// noc_credit_link_if: per-channel flit/credit link bundle plus credit monitor status
interface noc_credit_link_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int FLIT_WIDTH = 64,
  parameter int DEST_WIDTH = 6,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int PKT_CNT_WIDTH = 16
);
  localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
  logic [0:NUM_CHANNELS-1][FLIT_WIDTH-1:0] data_in, data_out;
  logic [0:NUM_CHANNELS-1][DEST_WIDTH-1:0] dest_in, dest_out;
  logic [0:NUM_CHANNELS-1] is_tail_in, is_tail_out, send_in, send_out, credit_in, credit_out;
  logic err_clr;
  logic [0:NUM_CHANNELS-1][CW-1:0] credit_avail;
  logic [0:NUM_CHANNELS-1] ovf_err, crd_err;
  logic [0:NUM_CHANNELS-1][PKT_CNT_WIDTH-1:0] pkt_cnt;
  modport master (
    output data_in, dest_in, is_tail_in, send_in, credit_in, err_clr,
    input data_out, dest_out, is_tail_out, send_out, credit_out, credit_avail, ovf_err, crd_err, pkt_cnt
  );
  modport slave (
    input data_in, dest_in, is_tail_in, send_in, credit_in, err_clr,
    output data_out, dest_out, is_tail_out, send_out, credit_out, credit_avail, ovf_err, crd_err, pkt_cnt
  );
endinterface

// File: rtl/noc_credit_link.sv
// noc_credit_link: pipelined multi-channel flit/credit link with an upstream credit monitor
module noc_credit_link #(
  parameter int NUM_CHANNELS = 4,
  parameter int FLIT_WIDTH = 64,
  parameter int DEST_WIDTH = 6,
  parameter int NUM_PIPELINE = 2,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int PKT_CNT_WIDTH = 16
) (
  input logic clk_noc,
  input logic rst_n,
  noc_credit_link_if.slave link
);
  localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FLIT_BUFFER_DEPTH);
  logic [0:NUM_CHANNELS-1] crd_ret;
  logic [0:NUM_CHANNELS-1][CW-1:0] avail;
  logic [0:NUM_CHANNELS-1] ovf, crd;
  logic [0:NUM_CHANNELS-1][PKT_CNT_WIDTH-1:0] cnt;
  generate
    if (NUM_PIPELINE == 0) begin : g_comb
      assign link.data_out = link.data_in;
      assign link.dest_out = link.dest_in;
      assign link.is_tail_out = link.is_tail_in;
      assign link.send_out = link.send_in;
      assign crd_ret = link.credit_in;
    end else begin : g_pipe
      logic [0:NUM_CHANNELS-1][FLIT_WIDTH-1:0] data_q [NUM_PIPELINE];
      logic [0:NUM_CHANNELS-1][DEST_WIDTH-1:0] dest_q [NUM_PIPELINE];
      logic [0:NUM_CHANNELS-1] tail_q [NUM_PIPELINE];
      logic [0:NUM_CHANNELS-1] send_q [NUM_PIPELINE];
      logic [0:NUM_CHANNELS-1] cred_q [NUM_PIPELINE];
      always_ff @(posedge clk_noc) begin
        data_q[0] <= link.data_in;
        dest_q[0] <= link.dest_in;
        tail_q[0] <= link.is_tail_in;
        for (int i = 1; i < NUM_PIPELINE; i++) begin
          data_q[i] <= data_q[i-1];
          dest_q[i] <= dest_q[i-1];
          tail_q[i] <= tail_q[i-1];
        end
      end
      always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
          for (int i = 0; i < NUM_PIPELINE; i++) begin
            send_q[i] <= '0;
            cred_q[i] <= '0;
          end
        end else begin
          send_q[0] <= link.send_in;
          cred_q[0] <= link.credit_in;
          for (int i = 1; i < NUM_PIPELINE; i++) begin
            send_q[i] <= send_q[i-1];
            cred_q[i] <= cred_q[i-1];
          end
        end
      end
      assign link.data_out = data_q[NUM_PIPELINE-1];
      assign link.dest_out = dest_q[NUM_PIPELINE-1];
      assign link.is_tail_out = tail_q[NUM_PIPELINE-1];
      assign link.send_out = send_q[NUM_PIPELINE-1];
      assign crd_ret = cred_q[NUM_PIPELINE-1];
    end
  endgenerate
  always_ff @(posedge clk_noc) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!rst_n) begin
        avail[c] <= FULL;
        ovf[c] <= 1'b0;
        crd[c] <= 1'b0;
        cnt[c] <= '0;
      end else begin
        avail[c] <= (link.send_in[c] && !crd_ret[c] && avail[c] != '0) ? avail[c] - CW'(1) :
                    (crd_ret[c] && !link.send_in[c] && avail[c] != FULL) ? avail[c] + CW'(1) : avail[c];
        ovf[c] <= (link.send_in[c] && !crd_ret[c] && avail[c] == '0) || (ovf[c] && !link.err_clr);
        crd[c] <= (crd_ret[c] && !link.send_in[c] && avail[c] == FULL) || (crd[c] && !link.err_clr);
        cnt[c] <= cnt[c] + PKT_CNT_WIDTH'(link.send_in[c] && link.is_tail_in[c]);
      end
    end
  end
  assign link.credit_out = crd_ret;
  assign link.credit_avail = avail;
  assign link.ovf_err = ovf;
  assign link.crd_err = crd;
  assign link.pkt_cnt = cnt;
endmodule

// File: doc/noc_credit_link.md
NOC_CREDIT_LINK -- requirements
Module: noc_credit_link

Interface
- REQ-001 Parameter NUM_CHANNELS, default 4: number of independent router-to-router links carried.
- REQ-002 Parameter FLIT_WIDTH, default 64: flit payload width.
- REQ-003 Parameter DEST_WIDTH, default 6: flit destination field width.
- REQ-004 Parameter NUM_PIPELINE, default 2: register stages on both the forward path and the credit-return path; the range is 0 to 8.
- REQ-005 Parameter FLIT_BUFFER_DEPTH, default 2: downstream input buffer depth, which is also the initial credit count.
- REQ-006 Parameter PKT_CNT_WIDTH, default 16: width of the per-channel packet counter.
- REQ-007 clk_noc input 1: the single clock; all logic is on the rising edge.
- REQ-008 rst_n input 1: reset, synchronous, active-low.
- REQ-009 data_in input [0:NUM_CHANNELS-1][FLIT_WIDTH-1:0]: flit data from the upstream router.
- REQ-010 dest_in input [0:NUM_CHANNELS-1][DEST_WIDTH-1:0]: flit destination from the upstream router.
- REQ-011 is_tail_in input [0:NUM_CHANNELS-1]: marks the last flit of a packet.
- REQ-012 send_in input [0:NUM_CHANNELS-1]: flit valid, one flit per cycle.
- REQ-013 credit_out output [0:NUM_CHANNELS-1]: credit returned to the upstream router.
- REQ-014 data_out, dest_out, is_tail_out, send_out outputs, same widths as the matching inputs: flit toward the downstream router.
- REQ-015 credit_in input [0:NUM_CHANNELS-1]: credit from the downstream router.
- REQ-016 err_clr input 1: clears all sticky error flags.
- REQ-017 credit_avail output [0:NUM_CHANNELS-1][$clog2(FLIT_BUFFER_DEPTH+1)-1:0]: credits currently held by the upstream sender.
- REQ-018 ovf_err output [0:NUM_CHANNELS-1]: sticky flag, a flit was sent with zero credits.
- REQ-019 crd_err output [0:NUM_CHANNELS-1]: sticky flag, a credit was returned while the count was already at FLIT_BUFFER_DEPTH.
- REQ-020 pkt_cnt output [0:NUM_CHANNELS-1][PKT_CNT_WIDTH-1:0]: number of tail flits accepted on send_in.

Function
- REQ-021 Forward path, NUM_PIPELINE=N>0: {data, dest, is_tail, send} appear at the outputs exactly N cycles after the inputs.
- REQ-022 Forward path, N=0: the path is purely combinational pass-through.
- REQ-023 Credit path: credit_in reaches credit_out after exactly N cycles; when N=0 it passes through combinationally.
- REQ-024 Pipeline stages carry one flit and one credit per cycle with no stall or backpressure; the link never drops or duplicates a send or credit pulse.
- REQ-025 Channels are fully independent; activity on one channel never affects another.
- REQ-026 Credit monitor, per channel, at the upstream boundary:
  - send_in alone: credit_avail decrements by 1.
  - credit_out alone: credit_avail increments by 1.
  - send_in and credit_out in the same cycle: credit_avail is unchanged.
- REQ-027 send_in while credit_avail=0 and no credit_out in the same cycle: ovf_err sets the next cycle, and credit_avail holds at 0 (saturates, no wrap).
- REQ-028 credit_out while credit_avail=FLIT_BUFFER_DEPTH and no send_in in the same cycle: crd_err sets the next cycle, and credit_avail holds at FLIT_BUFFER_DEPTH.
- REQ-029 Flits are always forwarded regardless of monitor errors; the monitor is observational only.
- REQ-030 pkt_cnt increments by 1 on each cycle with send_in=1 and is_tail_in=1, and wraps from all-ones to 0.
- REQ-031 err_clr=1 clears ovf_err and crd_err the next cycle. If an error condition occurs in the same cycle, the flag stays set (set wins).
- REQ-032 err_clr affects neither pkt_cnt nor credit_avail.

Reset
- REQ-033 While rst_n=0 at a clock edge:
  - all send and credit pipeline valid bits clear to 0, so send_out=0 and credit_out=0 when N>0;
  - credit_avail loads FLIT_BUFFER_DEPTH;
  - pkt_cnt loads 0;
  - ovf_err and crd_err load 0.
- REQ-034 Data, dest and is_tail pipeline registers are not reset; their values are don't-care while the matching valid bit is 0.
- REQ-035 Reset asserted mid-packet discards all in-flight flits and credits; no pulse emerges after rst_n rises.

Verification
- REQ-036 N=2, depth 2: send_in pulse on ch0 at cycle 10 with data 0xA5, dest 3 -> send_out[0]=1 with 0xA5 and dest 3 at cycle 12 only.
- REQ-037 Three sends on ch1 with no credits back, depth 2 -> credit_avail goes 2,1,0,0; ovf_err[1]=1 after the third send; three flits reach send_out.
- REQ-038 Simultaneous send_in and credit_out on ch2 with credit_avail=1 -> credit_avail stays 1; no error.
- REQ-039 credit_in pulse on ch3 with credit_avail=2, depth 2, N=2 -> credit_out[3] at +2 cycles; crd_err[3]=1 one cycle later; credit_avail stays 2.
- REQ-040 PKT_CNT_WIDTH=4, 17 tail flits on ch0 -> pkt_cnt[0]=1; the other channels read 0.
- REQ-041 rst_n low for one cycle with flits in flight at N=3 -> no send_out pulse afterwards; credit_avail=2 on all channels; all flags 0.
- REQ-042 Repeat REQ-036 to REQ-041 at N=0 with latencies adjusted to combinational.
